// File: rtl/token_pkg.sv
// Shared types and defaults for the token drain buffer.
// Imported by the counter and the top-level buffer.
package token_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/token_sat_counter.sv
// Saturating up/down counter holding the pending token count.
// sat_hit flags an increment that was refused because the count is at MAX.
module token_sat_counter
    import token_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    input  logic         hold,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         sat_hit
);

    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] ONE = W'(1);

    always_comb begin
        count_next = count;
        sat_hit    = 1'b0;
        if (clr) begin
            count_next = '0;
        end else if (!hold) begin
            if (inc && !dec) begin
                if (count == MAX) begin
                    sat_hit = 1'b1;
                end else begin
                    count_next = count + ONE;
                end
            end else if (dec && !inc && count != '0) begin
                count_next = count - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/token_drain_buffer.sv
// Buffers a single-bit token stream as a count and drains it over valid/ready.
// Saturation or upstream overflow locks the block in ERROR until clear.
module token_drain_buffer
    import token_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_token,
    input  logic             in_overflow,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pending,
    output logic [CNT_W-1:0] high_water,
    output logic             overflow
);

    state_t           state;
    state_t           state_nxt;
    logic             in_err;
    logic             accept;
    logic             fire;
    logic             sat_hit;
    logic [CNT_W-1:0] pend_nxt;
    logic [CNT_W-1:0] hw_nxt;

    assign in_err    = (state == ERROR);
    assign accept    = in_token && !in_err;
    assign out_valid = (pending != '0) && !in_err;
    assign fire      = out_valid && out_ready;
    assign overflow  = in_err;

    token_sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (accept),
        .dec        (fire),
        .clr        (clear),
        .hold       (in_err),
        .count      (pending),
        .count_next (pend_nxt),
        .sat_hit    (sat_hit)
    );

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, BUSY: begin
                    if (in_overflow || sat_hit) begin
                        state_nxt = ERROR;
                    end else if (pend_nxt != '0) begin
                        state_nxt = BUSY;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                ERROR:   state_nxt = ERROR;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign hw_nxt = (pend_nxt > high_water) ? pend_nxt : high_water;

    // Frozen in ERROR so the mark reflects the last healthy occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_water <= '0;
        end else if (clear) begin
            high_water <= '0;
        end else if (!in_err) begin
            high_water <= hw_nxt;
        end
    end

endmodule

// File: doc/token_drain_buffer.md
# token_drain_buffer

Downstream consumer of the token-doubling stage. Accepts its single-bit token stream and overflow flag, stores tokens as a pending count, and releases them one per cycle over a valid/ready handshake so a slower consumer can apply backpressure. Detects its own saturation and upstream overflow, then locks into an error state until explicitly cleared. Also records a pending-count high-water mark for performance monitoring.

## Interface
- CNT_W, 4: width of the pending counter and the high-water register; maximum pending is 2^CNT_W-1 (15 at default).

- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- in_token  input  1  one token arrives in every cycle this is high (driven by the doubling stage's b).
- in_overflow  input  1  upstream overflow flag; level-sensitive.
- clear  input  1  synchronous clear: leaves ERROR, zeroes all counters.
- out_valid  output  1  a token is available.
- out_ready  input  1  consumer accepts a token when high together with out_valid.
- pending  output  CNT_W  current stored token count.
- high_water  output  CNT_W  maximum value pending reached since reset or clear.
- overflow  output  1  sticky error flag; high exactly while in ERROR.

## Operation
- Definitions: accept = in_token && state != ERROR; fire = out_valid && out_ready.
- out_valid = (pending != 0) && state != ERROR. Combinational from registered state only; never depends on out_ready or in_token.
- Pending update: pending_next = pending + accept - fire. If both occur, pending is unchanged.
- States (enum): IDLE (pending == 0), BUSY (pending > 0), ERROR.
- IDLE -> BUSY when pending_next != 0. BUSY -> IDLE when pending_next == 0.
- Any non-ERROR state -> ERROR when in_overflow == 1.
- Any non-ERROR state -> ERROR when pending == MAX && accept && !fire (saturation). pending stays MAX; the token is lost.
- ERROR: out_valid = 0, in_token ignored, pending and high_water frozen, overflow = 1.
- ERROR -> IDLE only on clear.
- clear has priority over every other same-cycle event. In any state, the next state is IDLE with pending = 0, high_water = 0, overflow = 0. Tokens and fire in the clear cycle are discarded.
- high_water_next = max(high_water, pending_next), evaluated only outside ERROR and not on clear.
- All arithmetic is unsigned CNT_W bits. No wrap-around is permitted; saturation is the only out-of-range case.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, pending 0, high_water 0, overflow 0, out_valid 0. Reset mid-burst discards all stored tokens.
- Latency: a token accepted at edge N produces out_valid = 1 after edge N (same cycle visible as pending = 1). Minimum input-to-fire latency is 1 cycle.
- Throughput: one fire per cycle when out_ready is held high. With in_token held high and out_ready held high, pending stays constant.
- in_overflow is sampled at the edge: ERROR and overflow assert the cycle after in_overflow is seen high.
- Saturation error: overflow asserts one cycle after the offending edge, and out_valid drops at the same time.
- Handshake: out_valid, once high, stays high until fire, ERROR, or clear. The consumer may hold out_ready high indefinitely.

## Structure
- Shared package token_pkg holds:
  - the state enum typedef (IDLE, BUSY, ERROR);
  - the default CNT_W constant.
- One natural sub-module, token_sat_counter:
  - CNT_W up/down counter with inc, dec, clr and hold inputs;
  - outputs count and a sat_hit pulse.
- The FSM, high-water register and handshake logic stay in the top module.

## Test plan
- Reset and idle: hold rst_n low 2 cycles, then release. Expect pending = 0, out_valid = 0, overflow = 0, high_water = 0 for 10 idle cycles.
- Burst then drain:
  - 5 in_token cycles with out_ready = 0 -> pending = 5, high_water = 5.
  - Then out_ready = 1 -> exactly 5 fires on consecutive cycles, pending = 0, IDLE.
- Random stream conservation: 300 cycles of random in_token (30%) and out_ready (70%), then 100 drain cycles. Expect total fires = total in_token cycles and overflow = 0.
- Saturation: out_ready = 0 with in_token = 1 for 16 cycles. Expect pending = 15 after 15 cycles, overflow = 1 the cycle after the 16th, out_valid = 0, pending frozen at 15.
- Upstream overflow: pending = 3, pulse in_overflow for 1 cycle. Expect ERROR next cycle, out_valid = 0, and further in_token ignored with pending remaining 3.
- Clear priority: in ERROR, assert clear together with in_token = 1 and out_ready = 1. Expect the next cycle to show IDLE, pending = 0, high_water = 0, overflow = 0.
